// File: rtl/piezo_seq_pkg.sv
// rtl/piezo_seq_pkg.sv - shared state encoding and default timing for the piezo ping sequencer
package piezo_seq_pkg;

    localparam int DEF_GUARD_CYC = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GUARD_TX,
        ST_BURST,
        ST_GUARD_RX,
        ST_LISTEN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/piezo_txrx_sequencer_if.sv
// rtl/piezo_txrx_sequencer_if.sv - ping request/result bundle for the piezo sequencer
// master: issues ping requests, time base and echoes; slave: the sequencer side.
interface piezo_txrx_sequencer_if #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 32
);
    localparam int CH_W = $clog2(NUM_CH);

    logic              start;
    logic              abort;
    logic [CH_W-1:0]   ch_sel;
    logic [CNT_W-1:0]  half_period;
    logic [7:0]        num_pulses;
    logic [CNT_W-1:0]  rx_window;
    logic [TS_W-1:0]   time_base;
    logic [NUM_CH-1:0] echo;
    logic [NUM_CH-1:0] tx_en;
    logic [NUM_CH-1:0] rx_en;
    logic [NUM_CH-1:0] piezo;
    logic [NUM_CH-1:0] piezo_n;
    logic              busy;
    logic              done;
    logic              hit;
    logic [CH_W-1:0]   hit_ch;
    logic [TS_W-1:0]   timestamp;

    modport master (
        output start, abort, ch_sel, half_period, num_pulses, rx_window, time_base, echo,
        input  tx_en, rx_en, piezo, piezo_n, busy, done, hit, hit_ch, timestamp
    );

    modport slave (
        input  start, abort, ch_sel, half_period, num_pulses, rx_window, time_base, echo,
        output tx_en, rx_en, piezo, piezo_n, busy, done, hit, hit_ch, timestamp
    );

endinterface

// File: rtl/piezo_burst_gen.sv
// rtl/piezo_burst_gen.sv - square-wave burst of num_pulses periods with a half-period of H cycles
// Ports: iCLK/iRESETn clock and sync active-low reset; start_i loads a burst; stop_i cancels it;
// half_period_i (0 treated as 1) and num_pulses_i must stay stable during the burst;
// drive_o is the burst waveform (starts high); active_o is high for exactly 2*N*H cycles.
module piezo_burst_gen
    import piezo_seq_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             iCLK,
    input  logic             iRESETn,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] half_period_i,
    input  logic [7:0]       num_pulses_i,
    output logic             drive_o,
    output logic             active_o
);
    logic             drive_q, drive_d;
    logic             active_q, active_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [8:0]       halves_q, halves_d;
    logic [CNT_W-1:0] reload;

    // Cycles remaining in a half-period are counted down to 0, so reload is H-1.
    assign reload = (half_period_i == '0) ? '0 : half_period_i - CNT_W'(1);

    always_comb begin
        drive_d    = drive_q;
        active_d   = active_q;
        half_cnt_d = half_cnt_q;
        halves_d   = halves_q;
        if (stop_i) begin
            drive_d  = 1'b0;
            active_d = 1'b0;
        end else if (start_i && (num_pulses_i != 8'd0)) begin
            drive_d    = 1'b1;
            active_d   = 1'b1;
            half_cnt_d = reload;
            halves_d   = {num_pulses_i, 1'b0} - 9'd1;
        end else if (active_q) begin
            if (half_cnt_q == '0) begin
                if (halves_q == 9'd0) begin
                    drive_d  = 1'b0;
                    active_d = 1'b0;
                end else begin
                    drive_d    = ~drive_q;
                    halves_d   = halves_q - 9'd1;
                    half_cnt_d = reload;
                end
            end else begin
                half_cnt_d = half_cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            drive_q    <= 1'b0;
            active_q   <= 1'b0;
            half_cnt_q <= '0;
            halves_q   <= 9'd0;
        end else begin
            drive_q    <= drive_d;
            active_q   <= active_d;
            half_cnt_q <= half_cnt_d;
            halves_q   <= halves_d;
        end
    end

    assign drive_o  = drive_q;
    assign active_o = active_q;

endmodule

// File: rtl/piezo_txrx_sequencer.sv
// rtl/piezo_txrx_sequencer.sv - one-channel piezo ping: guard, burst, guard, listen, time-of-flight result
// Ports: iCLK/iRESETn clock and sync active-low reset; iStart/iAbort control; iCh_sel, iHalf_period,
// iNum_pulses, iRx_window ping setup (latched on start); iTime time base; iEcho async comparators;
// oTx_en/oRx_en/oPiezo/oPiezo_n per-channel drives; oBusy/oDone status; oHit/oHit_ch/oTimestamp result.
module piezo_txrx_sequencer
    import piezo_seq_pkg::*;
#(
    parameter int NUM_CH    = 3,
    parameter int CNT_W     = 16,
    parameter int TS_W      = 32,
    parameter int GUARD_CYC = DEF_GUARD_CYC
) (
    input  logic                      iCLK,
    input  logic                      iRESETn,
    input  logic                      iStart,
    input  logic                      iAbort,
    input  logic [$clog2(NUM_CH)-1:0] iCh_sel,
    input  logic [CNT_W-1:0]          iHalf_period,
    input  logic [7:0]                iNum_pulses,
    input  logic [CNT_W-1:0]          iRx_window,
    input  logic [TS_W-1:0]           iTime,
    input  logic [NUM_CH-1:0]         iEcho,
    output logic [NUM_CH-1:0]         oTx_en,
    output logic [NUM_CH-1:0]         oRx_en,
    output logic [NUM_CH-1:0]         oPiezo,
    output logic [NUM_CH-1:0]         oPiezo_n,
    output logic                      oBusy,
    output logic                      oDone,
    output logic                      oHit,
    output logic [$clog2(NUM_CH)-1:0] oHit_ch,
    output logic [TS_W-1:0]           oTimestamp
);
    localparam int CH_W = $clog2(NUM_CH);

    seq_state_t        state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CNT_W-1:0]  half_q, half_d;
    logic [7:0]        npulse_q, npulse_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  gcnt_q, gcnt_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic [TS_W-1:0]   tx_start_q, tx_start_d;
    logic              hit_q, hit_d;
    logic [CH_W-1:0]   hit_ch_q, hit_ch_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;

    logic              burst_start, burst_stop, burst_drive, burst_active;
    logic [NUM_CH-1:0] ch_mask, echo_rise;
    logic              accept, echo_valid, guard_last, win_last;

    assign ch_mask    = {{(NUM_CH-1){1'b0}}, 1'b1} << ch_q;
    assign echo_rise  = sync2_q & ~sync3_q;
    assign echo_valid = (state_q == ST_LISTEN) && |(echo_rise & ch_mask);
    assign accept     = iStart && !iAbort && (32'(iCh_sel) < NUM_CH);
    assign guard_last = (gcnt_q == CNT_W'(GUARD_CYC - 1));
    assign win_last   = (win_q == '0) || (wcnt_q == win_q - CNT_W'(1));

    piezo_burst_gen #(.CNT_W(CNT_W)) u_burst (
        .iCLK          (iCLK),
        .iRESETn       (iRESETn),
        .start_i       (burst_start),
        .stop_i        (burst_stop),
        .half_period_i (half_q),
        .num_pulses_i  (npulse_q),
        .drive_o       (burst_drive),
        .active_o      (burst_active)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        half_d      = half_q;
        npulse_d    = npulse_q;
        win_d       = win_q;
        gcnt_d      = gcnt_q;
        wcnt_d      = wcnt_q;
        tx_start_d  = tx_start_q;
        hit_d       = hit_q;
        hit_ch_d    = hit_ch_q;
        ts_d        = ts_q;
        burst_start = 1'b0;
        burst_stop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d  = ST_GUARD_TX;
                    ch_d     = iCh_sel;
                    half_d   = iHalf_period;
                    npulse_d = iNum_pulses;
                    win_d    = iRx_window;
                    gcnt_d   = '0;
                    hit_d    = 1'b0;
                    hit_ch_d = '0;
                    ts_d     = '0;
                end
            end
            ST_GUARD_TX: begin
                if (guard_last) begin
                    gcnt_d     = '0;
                    wcnt_d     = '0;
                    tx_start_d = iTime;
                    if (npulse_q == 8'd0) begin
                        state_d = ST_GUARD_RX;
                    end else begin
                        state_d     = ST_BURST;
                        burst_start = 1'b1;
                    end
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            ST_BURST: begin
                // The cycle in which the burst generator has just gone idle already has
                // both enables low, so it is counted as the first receive guard cycle.
                if (!burst_active) begin
                    state_d = (GUARD_CYC <= 1) ? ST_LISTEN : ST_GUARD_RX;
                    gcnt_d  = CNT_W'(1);
                    wcnt_d  = '0;
                end
            end
            ST_GUARD_RX: begin
                if (guard_last) begin
                    state_d = ST_LISTEN;
                    wcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + CNT_W'(1);
                end
            end
            ST_LISTEN: begin
                // A hit seen in the final window cycle wins over the timeout.
                if (echo_valid) begin
                    state_d  = ST_DONE;
                    hit_d    = 1'b1;
                    hit_ch_d = ch_q;
                    ts_d     = iTime - tx_start_q;
                end else if (win_last) begin
                    state_d = ST_DONE;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (iAbort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            hit_d       = 1'b0;
            burst_start = 1'b0;
            burst_stop  = 1'b1;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            half_q     <= '0;
            npulse_q   <= 8'd0;
            win_q      <= '0;
            gcnt_q     <= '0;
            wcnt_q     <= '0;
            tx_start_q <= '0;
            hit_q      <= 1'b0;
            hit_ch_q   <= '0;
            ts_q       <= '0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            half_q     <= half_d;
            npulse_q   <= npulse_d;
            win_q      <= win_d;
            gcnt_q     <= gcnt_d;
            wcnt_q     <= wcnt_d;
            tx_start_q <= tx_start_d;
            hit_q      <= hit_d;
            hit_ch_q   <= hit_ch_d;
            ts_q       <= ts_d;
        end
    end

    // Two flops for metastability, a third to detect the rising edge.
    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
        end else begin
            sync1_q <= iEcho;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign oTx_en     = burst_active ? ch_mask : '0;
    assign oRx_en     = (state_q == ST_LISTEN) ? ch_mask : '0;
    assign oPiezo     = (burst_active && burst_drive) ? ch_mask : '0;
    assign oPiezo_n   = (burst_active && !burst_drive) ? ch_mask : '0;
    assign oBusy      = (state_q != ST_IDLE);
    assign oDone      = (state_q == ST_DONE);
    assign oHit       = hit_q;
    assign oHit_ch    = hit_ch_q;
    assign oTimestamp = ts_q;

endmodule

// File: tb/tb_piezo_txrx_sequencer.sv
// tb/tb_piezo_txrx_sequencer.sv - self-checking bench for piezo_txrx_sequencer
module tb_piezo_txrx_sequencer;
    import piezo_seq_pkg::*;

    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int TS_W   = 32;
    localparam int G      = DEF_GUARD_CYC;

    logic        iCLK    = 1'b0;
    logic        iRESETn = 1'b0;
    logic [31:0] tb_time = 32'd0;
    logic [31:0] load_val = 32'd0;
    logic        load_req = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;
    bit          prev_hit = 1'b0;
    logic [1:0]  prev_ch  = 2'd0;
    logic [31:0] prev_ts  = 32'd0;

    piezo_txrx_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W)) bus ();

    piezo_txrx_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .TS_W(TS_W), .GUARD_CYC(G)) dut (
        .iCLK         (iCLK),
        .iRESETn      (iRESETn),
        .iStart       (bus.start),
        .iAbort       (bus.abort),
        .iCh_sel      (bus.ch_sel),
        .iHalf_period (bus.half_period),
        .iNum_pulses  (bus.num_pulses),
        .iRx_window   (bus.rx_window),
        .iTime        (bus.time_base),
        .iEcho        (bus.echo),
        .oTx_en       (bus.tx_en),
        .oRx_en       (bus.rx_en),
        .oPiezo       (bus.piezo),
        .oPiezo_n     (bus.piezo_n),
        .oBusy        (bus.busy),
        .oDone        (bus.done),
        .oHit         (bus.hit),
        .oHit_ch      (bus.hit_ch),
        .oTimestamp   (bus.timestamp)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) tb_time <= load_req ? load_val : tb_time + 32'd1;
    assign bus.time_base = tb_time;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_assert++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic set_time(input logic [31:0] v);
        @(negedge iCLK);
        load_val = v;
        load_req = 1'b1;
        @(negedge iCLK);
        load_req = 1'b0;
    endtask

    task automatic check_idle(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge iCLK);
            bus.start = 1'b0;
            chk({name, " idle drives"}, {bus.tx_en, bus.rx_en, bus.piezo, bus.piezo_n}, 64'd0);
            chk({name, " idle busy/done"}, {bus.busy, bus.done}, 64'd0);
            chk({name, " held result"}, {bus.hit, bus.hit_ch, bus.timestamp}, {prev_hit, prev_ch, prev_ts});
        end
    endtask

    // Expected behaviour is derived from the phase lengths: G guard cycles, a burst of
    // 2*N*max(H,1) cycles, G guard cycles, then at most max(W,1) listen cycles. Cycle r is
    // the cycle following the r-th clock edge after the start was sampled (r=0).
    task automatic do_ping(input string name, input int ch, input int h, input int n, input int w,
                           input int echo_k, input int echo_ch, input int abort_at,
                           input int reset_at, input int extra_at);
        int heff, weff, len, ls, de, stop, limit, txc, tog;
        bit hit, stopped, in_b, p, was_p, fin;
        logic [31:0] t0, exp_ts;
        logic [2:0] m, e_tx, e_rx, e_p, e_pn;
        heff  = (h == 0) ? 1 : h;
        weff  = (w == 0) ? 1 : w;
        len   = 2 * n * heff;
        ls    = 2 * G + len;
        hit   = (echo_k >= 1) && (echo_ch == ch) && (echo_k + 1 >= ls) && (echo_k + 1 < ls + weff);
        de    = hit ? echo_k + 2 : ls + weff;
        stop  = (abort_at >= 0) ? abort_at : reset_at;
        limit = (stop >= 0) ? stop + 4 : de + 2;
        m     = 3'b001 << ch;
        @(negedge iCLK);
        bus.ch_sel      = 2'(ch);
        bus.half_period = 16'(h);
        bus.num_pulses  = 8'(n);
        bus.rx_window   = 16'(w);
        bus.start       = 1'b1;
        t0     = tb_time;
        exp_ts = hit ? ((t0 + 32'(de)) - (t0 + 32'(G))) : 32'd0;
        txc = 0; tog = 0; was_p = 1'b0;
        for (int r = 0; r <= limit; r++) begin
            @(negedge iCLK);
            bus.start = 1'b0;
            bus.abort = 1'b0;
            iRESETn   = 1'b1;
            stopped = (stop >= 0) && (r >= stop);
            in_b    = !stopped && (n > 0) && (r >= G) && (r < G + len);
            p       = in_b && (((r - G) / heff) % 2 == 0);
            fin     = !stopped && (r >= de);
            e_tx = in_b ? m : 3'b000;
            e_p  = p ? m : 3'b000;
            e_pn = (in_b && !p) ? m : 3'b000;
            e_rx = (!stopped && r >= ls && r < de) ? m : 3'b000;
            chk($sformatf("%s r%0d tx_en", name, r), bus.tx_en, e_tx);
            chk($sformatf("%s r%0d rx_en", name, r), bus.rx_en, e_rx);
            chk($sformatf("%s r%0d piezo", name, r), bus.piezo, e_p);
            chk($sformatf("%s r%0d piezo_n", name, r), bus.piezo_n, e_pn);
            chk($sformatf("%s r%0d busy", name, r), bus.busy, !stopped && r <= de);
            chk($sformatf("%s r%0d done", name, r), bus.done, !stopped && r == de);
            chk($sformatf("%s r%0d hit", name, r), {bus.hit, bus.hit_ch}, {fin && hit, (fin && hit) ? 2'(ch) : 2'd0});
            chk($sformatf("%s r%0d timestamp", name, r), bus.timestamp, fin ? exp_ts : 32'd0);
            txc += int'(bus.tx_en[ch]);
            if (bus.piezo[ch] != was_p) tog++;
            was_p = bus.piezo[ch];
            if (r + 1 == echo_k)   bus.echo[echo_ch] = 1'b1;
            if (r + 1 == abort_at) bus.abort = 1'b1;
            if (r + 1 == reset_at) iRESETn = 1'b0;
            if (r + 1 == extra_at) begin
                bus.start      = 1'b1;
                bus.ch_sel     = 2'((ch + 1) % NUM_CH);
                bus.num_pulses = 8'd0;
            end
        end
        bus.echo = '0;
        if (stop < 0) begin
            chk({name, " tx_en cycles"}, 64'(txc), 64'(len));
            chk({name, " piezo toggles"}, 64'(tog), 64'(2 * n));
            prev_hit = hit;
            prev_ch  = hit ? 2'(ch) : 2'd0;
            prev_ts  = exp_ts;
        end else begin
            prev_hit = 1'b0;
            prev_ch  = 2'd0;
            prev_ts  = 32'd0;
        end
        check_idle(name, 4);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.ch_sel      = 2'd0;
        bus.half_period = 16'd0;
        bus.num_pulses  = 8'd0;
        bus.rx_window   = 16'd0;
        bus.echo        = '0;
        iRESETn         = 1'b0;
        repeat (3) @(posedge iCLK);
        @(negedge iCLK);
        chk("reset drives", {bus.tx_en, bus.rx_en, bus.piezo, bus.piezo_n}, 64'd0);
        chk("reset status", {bus.busy, bus.done, bus.hit, bus.hit_ch}, 64'd0);
        chk("reset timestamp", bus.timestamp, 64'd0);
        iRESETn = 1'b1;
        check_idle("post reset", 2);

        // basic ping with an ignored start request while busy
        do_ping("basic", 1, 2, 3, 100, 24, 1, -1, -1, 10);
        chk("basic timestamp", bus.timestamp, 32'd22);
        // timeout after 10 listen cycles
        do_ping("timeout", 2, 1, 1, 10, -1, 0, -1, -1, -1);
        // iTime wrap: tx_start 0xFFFFFFF0, hit at 0x00000010
        set_time(32'hFFFF_FFEB);
        do_ping("wrap", 0, 1, 2, 100, 34, 0, -1, -1, -1);
        chk("wrap timestamp", bus.timestamp, 32'h20);
        // echoes on the wrong channel or outside LISTEN
        do_ping("wrong ch", 2, 1, 1, 12, 11, 0, -1, -1, -1);
        do_ping("early echo", 2, 2, 2, 8, 5, 2, -1, -1, -1);
        // abort during burst, reset during listen
        do_ping("abort", 0, 2, 2, 50, -1, 0, 7, -1, -1);
        do_ping("reset", 1, 1, 1, 50, -1, 0, -1, 13, -1);
        // out-of-range channel select is ignored
        @(negedge iCLK);
        bus.ch_sel = 2'd3; bus.num_pulses = 8'd1; bus.start = 1'b1;
        check_idle("bad ch", 4);
        // zero pulses, zero half-period, zero window, hit on last window cycle
        do_ping("no pulses", 1, 3, 0, 6, -1, 0, -1, -1, -1);
        do_ping("h zero", 0, 0, 2, 3, -1, 0, -1, -1, -1);
        do_ping("w zero", 2, 1, 1, 0, -1, 0, -1, -1, -1);
        do_ping("hit vs timeout", 0, 1, 1, 5, 13, 0, -1, -1, -1);

        for (int i = 0; i < 10; i++) begin
            do_ping($sformatf("rand%0d", i), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 20)), int'($urandom_range(1, 45)),
                    int'($urandom_range(0, 2)), -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/piezo_txrx_sequencer.md
PIEZO_TXRX_SEQUENCER -- requirements
Module: piezo_txrx_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 3, giving the number of piezo transceiver channels.
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the width of the period and window counters.
REQ-003 The block SHALL have parameter TS_W, default 32, giving the width of the timestamp.
REQ-004 The block SHALL have parameter GUARD_CYC, default 4, giving the TX/RX turnaround guard time in cycles.
REQ-005 The block SHALL have the following ports, in this order:
- iCLK  in  1  clock.
- iRESETn  in  1  reset: synchronous, active-low, sampled on iCLK.
- iStart  in  1  single-cycle request to start a ping.
- iAbort  in  1  cancels the ping in progress.
- iCh_sel  in  $clog2(NUM_CH)  selects the channel.
- iHalf_period  in  CNT_W  burst half-period in cycles.
- iNum_pulses  in  8  number of burst periods.
- iRx_window  in  CNT_W  listen timeout in cycles.
- iTime  in  TS_W  free-running time base (PTP time).
- iEcho  in  NUM_CH  asynchronous echo comparator inputs.
- oTx_en  out  NUM_CH  transmit driver enable per channel.
- oRx_en  out  NUM_CH  receive amplifier enable per channel.
- oPiezo  out  NUM_CH  burst drive, positive.
- oPiezo_n  out  NUM_CH  burst drive, complementary.
- oBusy  out  1  high while a ping is in progress.
- oDone  out  1  single-cycle completion pulse.
- oHit  out  1  high if an echo was detected.
- oHit_ch  out  $clog2(NUM_CH)  channel of the detected echo.
- oTimestamp  out  TS_W  time of flight in iTime units.

Function
REQ-006 The state machine SHALL have states IDLE, GUARD_TX, BURST, GUARD_RX, LISTEN and DONE.
REQ-007 In IDLE, iStart=1 with iCh_sel<NUM_CH SHALL latch iCh_sel, iHalf_period, iNum_pulses and iRx_window and enter GUARD_TX on the next edge; oBusy SHALL be 1 from that edge until the return to IDLE.
REQ-008 iStart SHALL be ignored outside IDLE, and also when iCh_sel>=NUM_CH.
REQ-009 GUARD_TX SHALL last exactly GUARD_CYC cycles, with all oTx_en and all oRx_en at 0.
REQ-010 On entering BURST, the block SHALL latch iTime as tx_start, set oTx_en[ch]=1 and set oPiezo[ch]=1.
REQ-011 In BURST, oPiezo[ch] SHALL toggle every H cycles, where H is the latched half-period, with 0 treated as 1.
REQ-012 BURST SHALL end after 2*N half-periods, where N is the latched pulse count; oPiezo[ch] then returns to 0.
REQ-013 N=0 SHALL skip BURST and go directly from GUARD_TX to GUARD_RX, with tx_start latched at that transition.
REQ-014 oPiezo_n[i] SHALL equal ~oPiezo[i] while oTx_en[i]=1, and 0 otherwise.
REQ-015 All outputs of non-selected channels SHALL be 0 at all times.
REQ-016 GUARD_RX SHALL last GUARD_CYC cycles, with oTx_en and oRx_en both 0, then enter LISTEN with oRx_en[ch]=1.
REQ-017 iEcho SHALL pass through a 2-flop synchroniser per channel, followed by rising-edge detection.
REQ-018 An edge on the selected channel is only valid in LISTEN; edges on any other channel, or in any other state, SHALL be ignored.
REQ-019 On the first valid edge, the block SHALL set oTimestamp = iTime - tx_start (modulo 2^TS_W, so it is correct across iTime wrap-around), set oHit=1 and oHit_ch=ch, and enter DONE.
REQ-020 If the edge count in LISTEN reaches the latched window value W, the block SHALL enter DONE with oHit=0 and oTimestamp=0; W=0 SHALL time out after 1 cycle.
REQ-021 If a valid edge and the timeout occur in the same cycle, the hit SHALL take precedence.
REQ-022 DONE SHALL assert oDone for exactly 1 cycle, with all enables at 0, then return to IDLE.
REQ-023 oHit, oHit_ch and oTimestamp SHALL hold their values until the next accepted iStart, which clears them.
REQ-024 iAbort=1 in any non-IDLE state SHALL return the block to IDLE on the next edge, with all enables and drive outputs at 0, no oDone pulse, and oHit=0.
REQ-025 iAbort SHALL have priority over iStart in the same cycle.
REQ-026 oTx_en[i] and oRx_en[i] SHALL never be 1 in the same cycle.

Reset
REQ-027 When iRESETn=0 at an iCLK edge, the block SHALL enter IDLE and clear every output to 0: oTx_en, oRx_en, oPiezo, oPiezo_n, oBusy, oDone, oHit, oHit_ch and oTimestamp.
REQ-028 Reset SHALL also clear the synchronisers, tx_start and all counters.
REQ-029 Reset asserted mid-operation SHALL take effect on the same edge, with no oDone pulse.

Structure
REQ-030 The state enum and the default GUARD_CYC SHALL be placed in a shared package, piezo_seq_pkg.
REQ-031 Burst toggling and counting SHALL be implemented in one sub-module, piezo_burst_gen, with inputs start, half_period and num_pulses, and outputs drive and active.

Verification
REQ-032 The bench SHALL cover a basic ping: NUM_CH=3, ch=1, H=2, N=3, W=100, echo 20 cycles after burst start -> oTx_en[1] high for 12 cycles, 6 oPiezo toggles, oHit=1, oHit_ch=1, oTimestamp=20 plus 2 cycles of synchroniser latency.
REQ-033 The bench SHALL cover timeout: no echo, W=10 -> oDone exactly 10 cycles after LISTEN entry, oHit=0, oTimestamp=0.
REQ-034 The bench SHALL cover time wrap: tx_start=0xFFFFFFF0, echo at iTime=0x00000010 -> oTimestamp=0x20.
REQ-035 The bench SHALL cover wrong-channel and early echoes: echo on ch0 during LISTEN on ch2, and echo on ch2 during BURST -> both ignored, result is a timeout.
REQ-036 The bench SHALL cover abort and reset: iAbort in BURST -> all outputs 0 next cycle, no oDone; then iRESETn=0 in LISTEN -> all outputs 0 the same edge.
REQ-037 The bench SHALL cover edge cases: iStart while busy or with iCh_sel=3 -> ignored; N=0 -> no oPiezo activity and a direct transition GUARD_TX -> GUARD_RX.
